ram_sequencer: RTL and testbench

Synchronous front-end for the 16×8 asynchronous-strobe RAM. It converts single-cycle valid/ready read/write requests into correctly ordered RAM pin activity: address/data setup, active-low strobe pulse, hold/capture, then response. After reset it also sweeps the whole RAM to a known value. It sits directly upstream of the RAM, between the control unit and the memory.

---
 rtl/abm_mem_pkg.sv | 22 ++
 rtl/ram_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ram_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/abm_mem_pkg.sv
// rtl/abm_mem_pkg.sv - shared types and constants for the strobe-RAM sequencer
//
// Purpose: FSM state encoding plus default geometry of the 16x8 strobe RAM.
// Ports: none (package).
package abm_mem_pkg;

    localparam int ABM_ADDR_W = 4;
    localparam int ABM_DATA_W = 8;
    localparam int ABM_DEPTH  = 1 << ABM_ADDR_W;

    typedef enum logic [2:0] {
        INIT_SETUP  = 3'd0,
        INIT_STROBE = 3'd1,
        INIT_HOLD   = 3'd2,
        IDLE        = 3'd3,
        SETUP       = 3'd4,
        STROBE      = 3'd5,
        FINISH      = 3'd6,
        RESP        = 3'd7
    } state_e;

endpackage

// File: rtl/ram_sequencer.sv
// rtl/ram_sequencer.sv - valid/ready front-end that sequences strobe-RAM pin activity
//
// Purpose: turns single-cycle read/write requests into setup / strobe / hold
// pin sequences on an asynchronous-strobe RAM, and sweeps the RAM to INIT_VAL
// after every reset.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata     request payload
//   rsp_valid/rsp_rdata           one-cycle completion pulse, read data
//   init_done                     post-reset sweep finished
//   mem_en_n                      RAM enable (rstn pin), low after reset
//   mem_addr/mem_wdata            RAM address and write data
//   mem_write_bar/mem_read_bar    active-low strobes
//   mem_oe_n/mem_rdata            active-low output enable, RAM read data
module ram_sequencer
    import abm_mem_pkg::*;
#(
    parameter int                ADDR_W     = ABM_ADDR_W,
    parameter int                DATA_W     = ABM_DATA_W,
    parameter int                STROBE_CYC = 1,
    parameter bit                INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              mem_en_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_bar,
    output logic              mem_read_bar,
    output logic              mem_oe_n,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              SW        = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [SW-1:0]   STB_LOAD  = SW'(STROBE_CYC - 1);
    // One spare bit keeps the terminal compare distinct from wrap-around.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    // run_q is low for the first cycle after reset so the FSM picks its
    // starting state (sweep or idle) on the release edge.
    logic              run_q;
    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [SW-1:0]     stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              init_done_q, init_done_d;
    logic              mem_en_n_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              write_bar_q, write_bar_d;
    logic              read_bar_q, read_bar_d;
    logic              oe_n_q, oe_n_d;
    logic              in_sweep, in_access;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        if (!run_q) begin
            cnt_d   = '0;
            state_d = INIT_EN ? INIT_SETUP : IDLE;
        end else begin
            case (state_q)
                INIT_SETUP: begin
                    stb_d   = STB_LOAD;
                    state_d = INIT_STROBE;
                end
                INIT_STROBE: begin
                    if (stb_q == '0) state_d = INIT_HOLD;
                    else             stb_d   = stb_q - SW'(1);
                end
                INIT_HOLD: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + (ADDR_W+1)'(1);
                        state_d = INIT_SETUP;
                    end
                end
                IDLE: begin
                    // req_ready is registered high exactly while in IDLE.
                    if (req_valid) begin
                        we_d    = req_we;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    stb_d   = STB_LOAD;
                    state_d = STROBE;
                end
                STROBE: begin
                    if (stb_q == '0) state_d = FINISH;
                    else             stb_d   = stb_q - SW'(1);
                end
                FINISH: begin
                    // oe_n is low during this cycle; capture at its end.
                    if (!we_q) rsp_rdata_d = mem_rdata;
                    state_d = RESP;
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered copies of what the next state requires.
        in_sweep  = (state_d == INIT_SETUP) || (state_d == INIT_STROBE) || (state_d == INIT_HOLD);
        in_access = (state_d == SETUP) || (state_d == STROBE) || (state_d == FINISH);

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        init_done_d = init_done_q | (state_d == IDLE);

        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (in_sweep) begin
            mem_addr_d  = cnt_d[ADDR_W-1:0];
            mem_wdata_d = INIT_VAL;
        end else if (in_access) begin
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end

        write_bar_d = !((state_d == INIT_STROBE) || ((state_d == STROBE) && we_d));
        read_bar_d  = !((state_d == STROBE) && !we_d);
        oe_n_d      = !((state_d == FINISH) && !we_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            stb_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
            mem_en_n_q  <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            write_bar_q <= 1'b1;
            read_bar_q  <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            run_q       <= 1'b1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
            mem_en_n_q  <= 1'b0;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            write_bar_q <= write_bar_d;
            read_bar_q  <= read_bar_d;
            oe_n_q      <= oe_n_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign init_done     = init_done_q;
    assign mem_en_n      = mem_en_n_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_write_bar = write_bar_q;
    assign mem_read_bar  = read_bar_q;
    assign mem_oe_n      = oe_n_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// tb/tb_ram_sequencer.sv - self-checking bench for ram_sequencer
module tb_ram_sequencer;
    import abm_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- DUT a: STROBE_CYC=1, INIT_VAL=A5 ----------------
    logic       a_rst = 1'b1, a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [3:0] a_req_addr = '0;
    logic [7:0] a_req_wdata = '0;
    logic       a_req_ready, a_rsp_valid, a_init_done, a_en_n, a_wb, a_rb, a_oe_n;
    logic [7:0] a_rsp_rdata, a_wdata, a_rdata;
    logic [3:0] a_addr;

    ram_sequencer #(.ADDR_W(4), .DATA_W(8), .STROBE_CYC(1), .INIT_EN(1'b1), .INIT_VAL(8'hA5)) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .init_done(a_init_done),
        .mem_en_n(a_en_n), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_write_bar(a_wb), .mem_read_bar(a_rb), .mem_oe_n(a_oe_n), .mem_rdata(a_rdata));

    logic [7:0] mem_a [ABM_DEPTH];
    logic [7:0] rl_a = 8'h00;
    always @(posedge clk) begin
        if (a_rst) begin
            for (int k = 0; k < ABM_DEPTH; k++) mem_a[k] <= 8'h11;
        end else begin
            if (!a_en_n && !a_wb) mem_a[a_addr] <= a_wdata;
            if (!a_en_n && !a_rb) rl_a <= mem_a[a_addr];
        end
    end
    assign a_rdata = a_oe_n ? 8'h00 : rl_a;

    int wb_cnt_a = 0, rb_cnt_a = 0, oe_cnt_a = 0, ovl_a = 0, rsp_cnt_a = 0;
    always @(negedge clk) begin
        if (!a_wb) wb_cnt_a++;
        if (!a_rb) rb_cnt_a++;
        if (!a_oe_n) oe_cnt_a++;
        if (!a_wb && !a_rb) ovl_a++;
        if (a_rsp_valid) rsp_cnt_a++;
    end

    // ---------------- DUT b: STROBE_CYC=3 ----------------
    logic       b_rst = 1'b1, b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [3:0] b_req_addr = '0;
    logic [7:0] b_req_wdata = '0;
    logic       b_req_ready, b_rsp_valid, b_init_done, b_en_n, b_wb, b_rb, b_oe_n;
    logic [7:0] b_rsp_rdata, b_wdata, b_rdata;
    logic [3:0] b_addr;

    ram_sequencer #(.ADDR_W(4), .DATA_W(8), .STROBE_CYC(3), .INIT_EN(1'b1), .INIT_VAL(8'h00)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_init_done),
        .mem_en_n(b_en_n), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_write_bar(b_wb), .mem_read_bar(b_rb), .mem_oe_n(b_oe_n), .mem_rdata(b_rdata));

    logic [7:0] mem_b [ABM_DEPTH];
    logic [7:0] rl_b = 8'h00;
    always @(posedge clk) begin
        if (b_rst) begin
            for (int k = 0; k < ABM_DEPTH; k++) mem_b[k] <= 8'h22;
        end else begin
            if (!b_en_n && !b_wb) mem_b[b_addr] <= b_wdata;
            if (!b_en_n && !b_rb) rl_b <= mem_b[b_addr];
        end
    end
    assign b_rdata = b_oe_n ? 8'h00 : rl_b;

    int widths[$];
    int rsp_t[$];
    int rsp_d[$];
    int wrun_b = 0, rrun_b = 0, ovl_b = 0;
    always @(negedge clk) begin
        if (!b_wb && !b_rb) ovl_b++;
        if (b_init_done) begin
            if (!b_wb) wrun_b++;
            else if (wrun_b != 0) begin widths.push_back(wrun_b); wrun_b = 0; end
            if (!b_rb) rrun_b++;
            else if (rrun_b != 0) begin widths.push_back(rrun_b); rrun_b = 0; end
            if (b_rsp_valid) begin rsp_t.push_back(cyc); rsp_d.push_back(int'(b_rsp_rdata)); end
        end
    end

    // ---------------- DUT c: INIT_EN=0 ----------------
    logic       c_rst = 1'b1;
    logic       c_req_ready, c_rsp_valid, c_init_done, c_en_n, c_wb, c_rb, c_oe_n;
    logic [7:0] c_rsp_rdata, c_wdata;
    logic [3:0] c_addr;

    ram_sequencer #(.ADDR_W(4), .DATA_W(8), .STROBE_CYC(1), .INIT_EN(1'b0), .INIT_VAL(8'h00)) u_c (
        .clk(clk), .rst(c_rst), .req_valid(1'b0), .req_ready(c_req_ready),
        .req_we(1'b0), .req_addr(4'h0), .req_wdata(8'h00),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .init_done(c_init_done),
        .mem_en_n(c_en_n), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_write_bar(c_wb), .mem_read_bar(c_rb), .mem_oe_n(c_oe_n), .mem_rdata(8'h00));

    // ---------------- helpers ----------------
    task automatic txn_a(input logic we, input logic [3:0] ad, input logic [7:0] wd,
                         output int lat, output int dw, output int dr, output int doe);
        int n, w0, r0, o0;
        n = 0;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        w0 = wb_cnt_a; r0 = rb_cnt_a; o0 = oe_cnt_a;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
        lat = n + 1;
        dw  = wb_cnt_a - w0;
        dr  = rb_cnt_a - r0;
        doe = oe_cnt_a - o0;
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tv[8];
    vec_t qb[4];

    initial begin
        int n, lat, dw, dr, doe, bad;
        logic rdy_seen;

        tv[0] = '{1'b1, 4'd7,  8'h3C, 8'h00};
        tv[1] = '{1'b0, 4'd7,  8'h00, 8'h3C};
        tv[2] = '{1'b1, 4'd15, 8'hFF, 8'h3C};
        tv[3] = '{1'b0, 4'd15, 8'h00, 8'hFF};
        tv[4] = '{1'b0, 4'd0,  8'h00, 8'hA5};
        tv[5] = '{1'b1, 4'd0,  8'h12, 8'hA5};
        tv[6] = '{1'b0, 4'd0,  8'h00, 8'h12};
        tv[7] = '{1'b0, 4'd3,  8'h00, 8'hA5};

        qb[0] = '{1'b1, 4'd2, 8'h77, 8'h00};
        qb[1] = '{1'b0, 4'd2, 8'h00, 8'h77};
        qb[2] = '{1'b1, 4'd9, 8'h9A, 8'h77};
        qb[3] = '{1'b0, 4'd9, 8'h00, 8'h9A};

        repeat (3) @(negedge clk);

        // Reset values
        chk("a_reset_ctrl", int'({a_req_ready, a_rsp_valid, a_init_done, a_wb, a_rb, a_oe_n, a_en_n}), 7'b0001111);
        chk("a_reset_data", int'({a_rsp_rdata, a_addr, a_wdata}), 0);
        chk("c_reset_init_done", int'(c_init_done), 0);

        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);

        chk("c_init_done_first", int'(c_init_done), 1);
        chk("c_ready_first", int'(c_req_ready), 1);
        chk("c_en_n_first", int'(c_en_n), 0);
        chk("a_en_n_first", int'(a_en_n), 0);

        // Sweep of DUT a
        n = 0; rdy_seen = 1'b0;
        while (!a_init_done && n < 200) begin
            if (a_req_ready) rdy_seen = 1'b1;
            @(negedge clk); n++;
        end
        chk("a_sweep_cycles", n, 48);
        chk("a_ready_during_sweep", int'(rdy_seen), 0);
        bad = 0;
        for (int k = 0; k < ABM_DEPTH; k++) if (mem_a[k] != 8'hA5) bad++;
        chk("a_sweep_mem_bad", bad, 0);

        // Table-driven single requests on DUT a
        for (int i = 0; i < 8; i++) begin
            txn_a(tv[i].we, tv[i].addr, tv[i].wdata, lat, dw, dr, doe);
            chk($sformatf("a_lat[%0d]", i), lat, 4);
            chk($sformatf("a_rdata[%0d]", i), int'(a_rsp_rdata), int'(tv[i].exp_rdata));
            chk($sformatf("a_wb_cycles[%0d]", i), dw, tv[i].we ? 1 : 0);
            chk($sformatf("a_rb_cycles[%0d]", i), dr, tv[i].we ? 0 : 1);
            chk($sformatf("a_oe_cycles[%0d]", i), doe, tv[i].we ? 0 : 1);
            if (tv[i].we) chk($sformatf("a_mem[%0d]", i), int'(mem_a[tv[i].addr]), int'(tv[i].wdata));
        end

        // DUT b: valid held high across 4 queued requests
        n = 0;
        while (!b_init_done && n < 200) begin @(negedge clk); n++; end
        chk("b_sweep_done", int'(b_init_done), 1);
        begin
            int acc_t[4];
            b_req_valid = 1'b1;
            b_req_we = qb[0].we; b_req_addr = qb[0].addr; b_req_wdata = qb[0].wdata;
            for (int i = 0; i < 4; i++) begin
                n = 0;
                while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
                chk($sformatf("b_accept_wait[%0d]", i), int'(n < 50), 1);
                acc_t[i] = cyc;
                @(negedge clk);
                if (i < 3) begin
                    b_req_we = qb[i+1].we; b_req_addr = qb[i+1].addr; b_req_wdata = qb[i+1].wdata;
                end else begin
                    b_req_valid = 1'b0;
                end
            end
            n = 0;
            while (rsp_t.size() < 4 && n < 50) begin @(negedge clk); n++; end
            repeat (2) @(negedge clk);
            chk("b_rsp_count", rsp_t.size(), 4);
            chk("b_strobe_count", widths.size(), 4);
            for (int i = 0; i < 4; i++) begin
                if (i < rsp_t.size()) begin
                    chk($sformatf("b_lat[%0d]", i), rsp_t[i] - acc_t[i], 6);
                    if (!qb[i].we) chk($sformatf("b_rdata[%0d]", i), rsp_d[i], int'(qb[i].exp_rdata));
                end
                if (i < widths.size()) chk($sformatf("b_strobe_w[%0d]", i), widths[i], 3);
                if (i > 0) chk($sformatf("b_spacing[%0d]", i), acc_t[i] - acc_t[i-1], 7);
            end
        end

        // Reset during the strobe of a write to addr 3
        begin
            int rsp0;
            n = 0;
            while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
            rsp0 = rsp_cnt_a;
            a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd3; a_req_wdata = 8'h55;
            @(negedge clk);
            a_req_valid = 1'b0;
            @(negedge clk);
            chk("a_rst_in_strobe", int'(a_wb), 0);
            a_rst = 1'b1;
            @(negedge clk);
            chk("a_rst_pins", int'({a_wb, a_rb, a_oe_n, a_en_n, a_rsp_valid, a_req_ready}), 6'b111100);
            @(negedge clk);
            a_rst = 1'b0;
            n = 0;
            while (!a_init_done && n < 200) begin @(negedge clk); n++; end
            chk("a_resweep_cycles", n, 49);
            chk("a_resweep_addr3", int'(mem_a[3]), 8'hA5);
            chk("a_dropped_rsp", rsp_cnt_a - rsp0, 0);
        end

        chk("a_strobe_overlap", ovl_a, 0);
        chk("b_strobe_overlap", ovl_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
